// File: rtl/j_sat_arb_if.sv
// Operand/result handshake bundle shared by the two requesters, the saturator and its consumer.
interface j_sat_arb_if #(parameter int TAGW = 2);
    logic            req0_valid;
    logic            req0_ready;
    logic [39:0]     req0_acc;
    logic            req0_sz;
    logic [TAGW-1:0] req0_tag;
    logic            req1_valid;
    logic            req1_ready;
    logic [39:0]     req1_acc;
    logic            req1_sz;
    logic [TAGW-1:0] req1_tag;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_q;
    logic            out_src;
    logic [TAGW-1:0] out_tag;
    logic            out_sat;

    modport master (
        output req0_valid, req0_acc, req0_sz, req0_tag, input req0_ready,
        output req1_valid, req1_acc, req1_sz, req1_tag, input req1_ready,
        input  out_valid, out_q, out_src, out_tag, out_sat, output out_ready
    );

    modport slave (
        input  req0_valid, req0_acc, req0_sz, req0_tag, output req0_ready,
        input  req1_valid, req1_acc, req1_sz, req1_tag, output req1_ready,
        output out_valid, out_q, out_src, out_tag, out_sat, input out_ready
    );
endinterface

// File: rtl/j_sat_arb.sv
// Two-requester arbiter in front of a shared 16/32-bit saturator; result valid 2 cycles after the handshake, 1/cycle.
// Backpressure: S1+S2 hold at most two operands while out_ready is low, then both request readies drop.
module j_sat_arb #(
    parameter int TAGW = 2,
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        resetl,
    j_sat_arb_if.slave  bus,
    input  logic        clr_cnt,
    output logic [15:0] sat_cnt
);
    logic            s1_v;
    logic [39:0]     s1_acc;
    logic            s1_sz;
    logic [TAGW-1:0] s1_tag;
    logic            s1_src;
    logic            s2_v;
    logic [31:0]     s2_q;
    logic            s2_src;
    logic [TAGW-1:0] s2_tag;
    logic            s2_sat;
    logic            rr_ptr;
    logic [15:0]     cnt;

    logic            s2_load;
    logic            s1_free;
    logic            grant0;
    logic            grant1;
    logic [31:0]     d;
    logic [31:0]     sat_q;
    logic            pos16, neg16, pos32, neg32, sat_hit;

    assign s2_load = s1_v & (~s2_v | bus.out_ready);
    assign s1_free = ~s1_v | s2_load;

    // Pointer only matters when both request; fixed priority ignores it entirely.
    assign grant0 = bus.req0_valid & (~bus.req1_valid | ~FAIR | ~rr_ptr);
    assign grant1 = bus.req1_valid & ~grant0;

    assign bus.req0_ready = s1_free & grant0;
    assign bus.req1_ready = s1_free & grant1;

    assign d     = s1_acc[31:0];
    assign pos16 = ~s1_sz & ~d[31] & (|d[30:15]);
    assign neg16 = ~s1_sz &  d[31] & ~(&d[30:15]);
    assign pos32 =  s1_sz & ~s1_acc[39] & (|s1_acc[38:31]);
    assign neg32 =  s1_sz &  s1_acc[39] & ~(&s1_acc[38:31]);
    assign sat_hit = pos16 | neg16 | pos32 | neg32;

    always_comb begin
        sat_q = d;
        if (pos16)      sat_q = 32'h0000_7FFF;
        else if (neg16) sat_q = 32'hFFFF_8000;
        else if (pos32) sat_q = 32'h7FFF_FFFF;
        else if (neg32) sat_q = 32'h8000_0000;
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            s1_v   <= 1'b0;
            s1_acc <= '0;
            s1_sz  <= 1'b0;
            s1_tag <= '0;
            s1_src <= 1'b0;
            s2_v   <= 1'b0;
            s2_q   <= '0;
            s2_src <= 1'b0;
            s2_tag <= '0;
            s2_sat <= 1'b0;
            rr_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (bus.req0_ready | bus.req1_ready) begin
                s1_v   <= 1'b1;
                s1_acc <= bus.req1_ready ? bus.req1_acc : bus.req0_acc;
                s1_sz  <= bus.req1_ready ? bus.req1_sz  : bus.req0_sz;
                s1_tag <= bus.req1_ready ? bus.req1_tag : bus.req0_tag;
                s1_src <= bus.req1_ready;
                rr_ptr <= ~rr_ptr;
            end else if (s2_load) begin
                s1_v <= 1'b0;
            end

            if (s2_load) begin
                s2_v   <= 1'b1;
                s2_q   <= sat_q;
                s2_src <= s1_src;
                s2_tag <= s1_tag;
                s2_sat <= sat_hit;
            end else if (bus.out_ready) begin
                s2_v <= 1'b0;
            end

            // Clear wins over a same-cycle event; the count sticks at all-ones.
            if (clr_cnt)
                cnt <= '0;
            else if (s2_load & sat_hit & ~(&cnt))
                cnt <= cnt + 16'd1;
        end
    end

    assign bus.out_valid = s2_v;
    assign bus.out_q     = s2_q;
    assign bus.out_src   = s2_src;
    assign bus.out_tag   = s2_tag;
    assign bus.out_sat   = s2_sat;
    assign sat_cnt       = cnt;
endmodule

// File: tb/tb_j_sat_arb.sv
// Scoreboard bench for j_sat_arb: drivers push model results on handshake, a negedge monitor pops and compares.
module tb_j_sat_arb;
    localparam int TAGW = 2;
    localparam bit FAIR = 1'b1;

    typedef struct {
        logic [31:0]     q;
        logic            src;
        logic [TAGW-1:0] tag;
        logic            sat;
    } res_t;

    logic        clk = 1'b0;
    logic        resetl = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        clr2 = 1'b0;
    logic [15:0] sat_cnt;
    logic [15:0] cnt2;

    always #5 clk = ~clk;

    j_sat_arb_if #(.TAGW(TAGW)) b();
    j_sat_arb_if #(.TAGW(TAGW)) b2();

    j_sat_arb #(.TAGW(TAGW), .FAIR(1'b1)) dut (
        .clk(clk), .resetl(resetl), .bus(b), .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
    );
    j_sat_arb #(.TAGW(TAGW), .FAIR(1'b0)) dut_fp (
        .clk(clk), .resetl(resetl), .bus(b2), .clr_cnt(clr2), .sat_cnt(cnt2)
    );

    res_t        exp_q[$];
    int          src_log[$];
    int          occ = 0;
    int          ptr_m = 0;
    logic [15:0] cnt_m = '0;
    int          total = 0;
    int          bad = 0;
    bit          hold_p = 1'b0;
    res_t        held;
    bit          rnd_done, bp_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at t=%0t", name, $time);
    endtask

    // Saturation expressed as a signed range clamp on the selected width.
    function automatic res_t ref_model(input logic [39:0] acc, input logic sz, input logic src,
                                       input logic [TAGW-1:0] tag);
        res_t   r;
        longint v;
        r.q = acc[31:0]; r.sat = 1'b0; r.src = src; r.tag = tag;
        if (!sz) begin
            v = longint'($signed(acc[31:0]));
            if (v > 64'sd32767)       begin r.q = 32'h0000_7FFF; r.sat = 1'b1; end
            else if (v < -64'sd32768) begin r.q = 32'hFFFF_8000; r.sat = 1'b1; end
        end else begin
            v = longint'($signed(acc));
            if (v > 64'sd2147483647)       begin r.q = 32'h7FFF_FFFF; r.sat = 1'b1; end
            else if (v < -64'sd2147483648) begin r.q = 32'h8000_0000; r.sat = 1'b1; end
        end
        return r;
    endfunction

    function automatic logic [39:0] rnd_acc();
        int unsigned k, lo, hi;
        int          s;
        logic [39:0] a;
        k  = $urandom_range(0, 3);
        lo = $urandom;
        hi = $urandom;
        s  = int'($urandom_range(0, 65543)) - 32772;
        case (k)
            0: a = {{8{s[31]}}, s};
            1: begin
                a = {{8{lo[31]}}, lo};
                if (hi[0]) a[32] = ~a[32];
            end
            2: a = {hi[7:0], lo};
            default: a = {hi[7:0], s};
        endcase
        return a;
    endfunction

    task automatic model_accept(input int n, input logic [39:0] a, input logic sz, input logic [TAGW-1:0] tag);
        res_t r;
        r = ref_model(a, sz, n[0], tag);
        exp_q.push_back(r);
        occ++;
        ptr_m = 1 - ptr_m;
        src_log.push_back(n);
        if (r.sat && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    endtask

    // Monitor: checks readies against the occupancy/pointer model, pops results, checks hold stability.
    initial forever begin
        logic free, e0, e1;
        res_t e;
        @(negedge clk);
        if (!resetl) begin
            hold_p = 1'b0;
        end else begin
            if (hold_p)
                chk("hold_stable", 64'({b.out_q, b.out_src, b.out_tag, b.out_sat}),
                    64'({held.q, held.src, held.tag, held.sat}));
            free = (occ < 2) || b.out_ready;
            e0 = free && b.req0_valid && (!b.req1_valid || !FAIR || ptr_m == 0);
            e1 = free && b.req1_valid && (!b.req0_valid || (FAIR && ptr_m == 1));
            chk("readies", 64'({b.req0_ready, b.req1_ready}), 64'({e0, e1}));
            if (b.out_valid && b.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_result: got q=0x%0h src=%0d with nothing expected", b.out_q, b.out_src);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 64'({b.out_q, b.out_src, b.out_tag, b.out_sat}),
                        64'({e.q, e.src, e.tag, e.sat}));
                    occ--;
                end
            end
            if (b.req0_valid && b.req0_ready) model_accept(0, b.req0_acc, b.req0_sz, b.req0_tag);
            if (b.req1_valid && b.req1_ready) model_accept(1, b.req1_acc, b.req1_sz, b.req1_tag);
            hold_p = b.out_valid && !b.out_ready;
            held.q = b.out_q; held.src = b.out_src; held.tag = b.out_tag; held.sat = b.out_sat;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic drive(input int n, input logic [39:0] a, input logic sz, input logic [TAGW-1:0] tag);
        int w = 0;
        bit done = 1'b0;
        if (n == 0) begin
            b.req0_acc = a; b.req0_sz = sz; b.req0_tag = tag; b.req0_valid = 1'b1;
        end else begin
            b.req1_acc = a; b.req1_sz = sz; b.req1_tag = tag; b.req1_valid = 1'b1;
        end
        while (!done) begin
            @(negedge clk);
            if ((n == 0) ? b.req0_ready : b.req1_ready) done = 1'b1;
            else if (++w > 500) begin expired("drive_accept"); done = 1'b1; end
        end
        @(posedge clk); #1;
        if (n == 0) b.req0_valid = 1'b0; else b.req1_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        b.out_ready = 1'b1;
        while (exp_q.size() != 0 && w < 2000) begin @(negedge clk); w++; end
        if (exp_q.size() != 0) expired("drain");
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [39:0] dacc [13] = '{40'h00_0001_0000, 40'hFF_FFFE_0000, 40'h01_0000_0000, 40'hFE_0000_0000,
                               40'h00_0000_7FFF, 40'h00_0000_8000, 40'hFF_FFFF_8000, 40'hFF_FFFF_7FFF,
                               40'h00_7FFF_FFFF, 40'h00_8000_0000, 40'hFF_8000_0000, 40'hFF_7FFF_FFFF,
                               40'hAB_0000_1234};
    logic        dsz  [13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        b.req0_valid = 0; b.req0_acc = '0; b.req0_sz = 0; b.req0_tag = '0;
        b.req1_valid = 0; b.req1_acc = '0; b.req1_sz = 0; b.req1_tag = '0;
        b.out_ready = 0;
        b2.req0_valid = 0; b2.req0_acc = '0; b2.req0_sz = 0; b2.req0_tag = '0;
        b2.req1_valid = 0; b2.req1_acc = '0; b2.req1_sz = 0; b2.req1_tag = '0;
        b2.out_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 64'({b.out_valid, b.out_q, b.out_src, b.out_tag, b.out_sat}), 64'd0);
        chk("rst_cnt", 64'(sat_cnt), 64'd0);
        resetl = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'({b.req0_ready, b.req1_ready}), 64'd0);
        @(posedge clk); #1;

        // First-transaction latency.
        b.out_ready = 1'b1;
        b.req0_acc = 40'h00_0000_1234; b.req0_sz = 1'b0; b.req0_tag = 2'd1; b.req0_valid = 1'b1;
        @(negedge clk);
        chk("lat_ready", 64'(b.req0_ready), 64'd1);
        @(posedge clk); #1;
        b.req0_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_valid", 64'(b.out_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 64'(b.out_valid), 64'd1);
        chk("lat_cycle2_data", 64'({b.out_q, b.out_src, b.out_sat}), 64'({32'h0000_1234, 1'b0, 1'b0}));
        @(posedge clk); #1;

        // Saturation corner cases, alternating requester.
        for (int i = 0; i < 13; i++) drive(i % 2, dacc[i], dsz[i], TAGW'(i));
        drain();
        chk("cnt_after_directed", 64'(sat_cnt), 64'(cnt_m));

        // Backpressure: three requests with out_ready low.
        b.out_ready = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                drive(0, 40'h00_0002_0000, 1'b0, 2'd0);
                drive(0, 40'h00_0000_0055, 1'b0, 2'd1);
                drive(0, 40'hFE_0000_0000, 1'b1, 2'd2);
                bp_done = 1'b1;
            end
        join_none
        repeat (8) @(negedge clk);
        chk("bp_readies", 64'({b.req0_valid, b.req0_ready, b.req1_ready}), 64'b100);
        chk("bp_out_valid", 64'(b.out_valid), 64'd1);
        chk("bp_held", 64'(exp_q.size()), 64'd2);
        @(posedge clk); #1;
        drain();
        for (int w = 0; w < 100 && !bp_done; w++) @(posedge clk);
        if (!bp_done) expired("bp_third");
        #1;

        // Randomized concurrent traffic with random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                fork
                    for (int i = 0; i < 300; i++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        drive(0, rnd_acc(), 1'($urandom_range(0, 1)), TAGW'($urandom));
                    end
                    for (int j = 0; j < 300; j++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        drive(1, rnd_acc(), 1'($urandom_range(0, 1)), TAGW'($urandom));
                    end
                join
                rnd_done = 1'b1;
            end
            while (!rnd_done) begin
                @(posedge clk); #1;
                b.out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        drain();
        chk("cnt_after_random", 64'(sat_cnt), 64'(cnt_m));

        // Long saturating run drives the counter into its ceiling.
        for (int i = 0; i < 65540; i++) drive(0, 40'h00_0001_0000, 1'b0, TAGW'(i));
        drain();
        chk("cnt_ceiling_model", 64'(sat_cnt), 64'(cnt_m));
        chk("cnt_ceiling", 64'(sat_cnt), 64'hFFFF);

        // Clear coinciding with a saturating result entering S2.
        for (int k = 0; k < 2; k++) begin
            drive(0, 40'hFF_FFFE_0000, 1'b0, 2'd3);
            clr_cnt = 1'b1;
            @(posedge clk); #1;
            clr_cnt = 1'b0;
            drain();
            chk("clr_concurrent", 64'(sat_cnt), 64'd0);
            cnt_m = '0;
        end

        // Reset with S1 and S2 full and the pointer parked on req1.
        if (ptr_m == 0) begin
            drive(0, 40'h00_0000_0001, 1'b0, 2'd0);
            drain();
        end
        b.out_ready = 1'b0;
        drive(0, 40'h01_0000_0000, 1'b1, 2'd1);
        drive(0, 40'h00_0000_0077, 1'b0, 2'd2);
        @(posedge clk); #2;
        resetl = 1'b0;
        exp_q.delete(); occ = 0; ptr_m = 0; cnt_m = '0;
        #1;
        chk("rst_mid_valid", 64'(b.out_valid), 64'd0);
        chk("rst_mid_cnt", 64'(sat_cnt), 64'd0);
        chk("rst_mid_out", 64'({b.out_q, b.out_src, b.out_tag, b.out_sat}), 64'd0);
        @(posedge clk); #1;
        resetl = 1'b1;

        // Both requesters continuously valid: grants alternate starting with req0.
        src_log.delete();
        b.out_ready = 1'b1;
        fork
            for (int i = 0; i < 4; i++) drive(0, rnd_acc(), 1'b0, TAGW'(i));
            for (int j = 0; j < 4; j++) drive(1, rnd_acc(), 1'b1, TAGW'(j));
        join
        drain();
        chk("alt_count", 64'(src_log.size()), 64'd8);
        for (int i = 0; i < src_log.size(); i++) chk("alt_order", 64'(src_log[i]), 64'(i % 2));

        // Fixed-priority instance: req0 always wins.
        b2.out_ready = 1'b1;
        b2.req0_acc = 40'h00_0000_0011; b2.req1_acc = 40'h00_0000_0022;
        b2.req0_valid = 1'b1; b2.req1_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("fp_readies", 64'({b2.req0_ready, b2.req1_ready}), 64'b10);
        end
        chk("fp_out", 64'({b2.out_valid, b2.out_src, b2.out_q}), 64'({1'b1, 1'b0, 32'h11}));
        @(posedge clk); #1;
        b2.req0_valid = 1'b0;
        @(negedge clk);
        chk("fp_req1_alone", 64'({b2.req0_ready, b2.req1_ready}), 64'b01);
        @(posedge clk); #1;
        b2.req1_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
